io_bidir_multi_bel: RTL

Parametrised bidirectional IO BEL for the west/east edge IO tiles. It carries NUM_CH independent pad channels; each channel has an optional output/tristate register, an input synchroniser, and a configurable capture stage: level, rising pulse, falling pulse or toggle. It sits between the tile switch matrix (fabric side: I, T, O, Q, CE) and the top-level pad wrapper (I_top, T_top, O_top). Per-channel mode comes from the tile config memory through ConfigBits.

---
 rtl/io_bel_pkg.sv | 31 +++
 rtl/io_bidir_cell.sv | 74 +++++++
 rtl/io_bidir_multi_bel.sv | 45 ++++
 3 files changed

// File: rtl/io_bel_pkg.sv
// Shared definitions for the edge IO BEL: config bit positions, Q capture modes
// and the decoded per-channel config record.
package io_bel_pkg;

    localparam int CFG_PER_CH   = 4;
    localparam int CFG_OREG     = 0;
    localparam int CFG_ISYNC    = 1;
    localparam int CFG_QMODE_LO = 2;

    typedef enum logic [1:0] {
        QM_LEVEL  = 2'b00,
        QM_RISE   = 2'b01,
        QM_FALL   = 2'b10,
        QM_TOGGLE = 2'b11
    } qmode_e;

    typedef struct packed {
        qmode_e qmode;
        logic   isync;
        logic   oreg;
    } ch_cfg_t;

    function automatic ch_cfg_t cfg_decode(input logic [CFG_PER_CH-1:0] bits);
        ch_cfg_t c;
        c.oreg  = bits[CFG_OREG];
        c.isync = bits[CFG_ISYNC];
        c.qmode = qmode_e'(bits[CFG_QMODE_LO +: 2]);
        return c;
    endfunction

endpackage

// File: rtl/io_bidir_cell.sv
// One bidirectional pad channel: output/tristate register with bypass, input
// synchroniser, and the CE-qualified Q capture stage.
module io_bidir_cell
    import io_bel_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  ch_cfg_t i_cfg,
    input  logic    i_i,
    input  logic    i_t,
    input  logic    i_ce,
    input  logic    i_pad_o,
    output logic    o_o,
    output logic    o_q,
    output logic    o_i_top,
    output logic    o_t_top
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_p;
    logic                   r_q;
    logic                   r_oi;
    logic                   r_ot;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_q_nxt;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_p;

    // Synchroniser and edge-history run free of CE and config.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_p    <= 1'b0;
        end else begin
            r_sync[0] <= i_pad_o;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_p <= w_s;
        end
    end

    always_comb begin
        w_q_nxt = r_q;
        case (i_cfg.qmode)
            QM_LEVEL:  w_q_nxt = w_s;
            QM_RISE:   w_q_nxt = w_rise;
            QM_FALL:   w_q_nxt = ~w_s & r_p;
            QM_TOGGLE: w_q_nxt = r_q ^ w_rise;
            default:   w_q_nxt = r_q;
        endcase
    end

    // Output registers track I/T even while bypassed so OREG can be enabled later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q  <= 1'b0;
            r_oi <= 1'b0;
            r_ot <= 1'b1;
        end else if (i_ce) begin
            r_q  <= w_q_nxt;
            r_oi <= i_i;
            r_ot <= i_t;
        end
    end

    assign o_i_top = i_cfg.oreg  ? r_oi : i_i;
    assign o_t_top = i_cfg.oreg  ? r_ot : i_t;
    assign o_o     = i_cfg.isync ? w_s  : i_pad_o;
    assign o_q     = r_q;

endmodule

// File: rtl/io_bidir_multi_bel.sv
// Multi-channel bidirectional IO BEL: slices ConfigBits per channel and
// instantiates one io_bidir_cell per pad.
module io_bidir_multi_bel
    import io_bel_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CFG_PER_CH  = 4
) (
    input  logic                       UserCLK,
    input  logic                       UserRSTn,
    input  logic [NUM_CH*CFG_PER_CH-1:0] ConfigBits,
    input  logic [NUM_CH-1:0]          I,
    input  logic [NUM_CH-1:0]          T,
    input  logic [NUM_CH-1:0]          CE,
    output logic [NUM_CH-1:0]          O,
    output logic [NUM_CH-1:0]          Q,
    output logic [NUM_CH-1:0]          I_top,
    output logic [NUM_CH-1:0]          T_top,
    input  logic [NUM_CH-1:0]          O_top
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_cfg_t w_cfg;

        assign w_cfg = cfg_decode(ConfigBits[k*CFG_PER_CH +: 4]);

        io_bidir_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .i_clk   (UserCLK),
            .i_rst_n (UserRSTn),
            .i_cfg   (w_cfg),
            .i_i     (I[k]),
            .i_t     (T[k]),
            .i_ce    (CE[k]),
            .i_pad_o (O_top[k]),
            .o_o     (O[k]),
            .o_q     (Q[k]),
            .o_i_top (I_top[k]),
            .o_t_top (T_top[k])
        );
    end

endmodule
